// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Reads a word-addressed instruction
//               memory at the current PC, latches the result into the IF/ID
//               pipeline register and produces the next PC for the PC
//               register. Handles stall, redirect/flush, the pre-start PC
//               value (-4) and sticky fetch faults.
//
// Ports       : clk          - rising-edge clock (shared with PC register)
//               rst          - synchronous active-high reset
//               pc           - current PC
//               stall        - hold PC and IF/ID
//               branchTaken  - taken conditional branch, target branchTarget
//               jump         - J/JAL redirect, target jumpTarget
//               jr           - JR redirect, target jrTarget
//               loadEn       - instruction memory write enable
//               loadAddr     - write byte address (bits [1:0] ignored)
//               loadData     - write data
//               nextPC       - combinational next PC
//               ifidInstr    - registered instruction
//               ifidPC4      - registered pc+4 of that instruction
//               ifidValid    - 1 = real instruction, 0 = bubble
//               fetchFault   - sticky misaligned/out-of-range fetch flag
//               instrCount   - number of valid instructions delivered
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter int          IMEM_WORDS = 256,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   input  logic        jump,
   input  logic [31:0] jumpTarget,
   input  logic        jr,
   input  logic [31:0] jrTarget,
   input  logic        loadEn,
   input  logic [31:0] loadAddr,
   input  logic [31:0] loadData,
   output logic [31:0] nextPC,
   output logic [31:0] ifidInstr,
   output logic [31:0] ifidPC4,
   output logic        ifidValid,
   output logic        fetchFault,
   output logic [31:0] instrCount
);

   localparam int          c_ADDR_W   = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
   // Byte-address limit, one bit wider than the PC so the compare never wraps.
   localparam logic [32:0] c_LIMIT    = 33'(IMEM_WORDS) << 2;
   localparam logic [31:0] c_PRESTART = 32'hFFFF_FFFC;

   logic [31:0]         r_mem [IMEM_WORDS];

   logic [31:0]         r_ifid_instr;
   logic [31:0]         r_ifid_pc4;
   logic                r_ifid_valid;
   logic                r_fetch_fault;
   logic [31:0]         r_instr_count;

   logic                w_redirect;
   logic                w_prestart;
   logic                w_fault;
   logic                w_ld_in_range;
   logic [c_ADDR_W-1:0] w_rd_idx;
   logic [c_ADDR_W-1:0] w_wr_idx;
   logic [31:0]         w_rd_word;
   logic [31:0]         w_pc_plus4;

   assign w_redirect    = jr | jump | branchTaken;
   assign w_prestart    = (pc == c_PRESTART);
   // The pre-start value is out of range but is deliberately not a fault.
   assign w_fault       = !w_prestart &&
                          ((pc[1:0] != 2'b00) || ({1'b0, pc} >= c_LIMIT));
   assign w_ld_in_range = ({1'b0, loadAddr} < c_LIMIT);
   assign w_rd_idx      = pc[c_ADDR_W+1:2];
   assign w_wr_idx      = loadAddr[c_ADDR_W+1:2];
   assign w_pc_plus4    = pc + 32'd4;

   // Asynchronous read; the write below is non-blocking, so a same-cycle
   // write to the word being fetched still returns the old contents.
   assign w_rd_word     = r_mem[w_rd_idx];

   always_comb begin
      nextPC = w_pc_plus4;
      if (rst)              nextPC = 32'd0;
      else if (jr)          nextPC = jrTarget;
      else if (jump)        nextPC = jumpTarget;
      else if (branchTaken) nextPC = branchTarget;
      else if (stall)       nextPC = pc;
   end

   // Program load runs regardless of reset and stall; memory is never cleared.
   always_ff @(posedge clk) begin
      if (loadEn && w_ld_in_range) begin
         r_mem[w_wr_idx] <= loadData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ifid_instr  <= NOP_WORD;
         r_ifid_pc4    <= 32'd0;
         r_ifid_valid  <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_instr_count <= 32'd0;
      end else if (w_redirect) begin
         // Flush wins over stall: the wrong-path instruction is discarded.
         r_ifid_instr  <= NOP_WORD;
         r_ifid_pc4    <= 32'd0;
         r_ifid_valid  <= 1'b0;
      end else if (!stall) begin
         if (w_prestart || w_fault) begin
            r_ifid_instr  <= NOP_WORD;
            r_ifid_pc4    <= 32'd0;
            r_ifid_valid  <= 1'b0;
            if (w_fault) begin
               r_fetch_fault <= 1'b1;
            end
         end else begin
            r_ifid_instr  <= w_rd_word;
            r_ifid_pc4    <= w_pc_plus4;
            r_ifid_valid  <= 1'b1;
            r_instr_count <= r_instr_count + 32'd1;
         end
      end
   end

   assign ifidInstr  = r_ifid_instr;
   assign ifidPC4    = r_ifid_pc4;
   assign ifidValid  = r_ifid_valid;
   assign fetchFault = r_fetch_fault;
   assign instrCount = r_instr_count;

endmodule
`default_nettype wire
